// File: rtl/text_console_ctrl.sv
// Text-console write engine: turns an ASCII stream into character-buffer write strobes,
// maintaining the cursor, a per-row line-end table and a hardware scroll offset.
module text_console_ctrl #(
    parameter int COLS  = 70,
    parameter int ROWS  = 30,
    parameter int COL_W = 7,
    parameter int ROW_W = 5,
    parameter int TAB_W = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [COL_W+ROW_W-1:0] wr_addr,
    output logic [7:0]             wr_data,
    output logic [ROW_W-1:0]       scroll_offset,
    output logic [COL_W-1:0]       cur_col,
    output logic [ROW_W-1:0]       cur_row,
    output logic                   clearing
);
    localparam int BUF_ROWS  = 1 << ROW_W;
    localparam int TAB_SUM_W = COL_W + 1;
    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]     COLS_END = COL_W'(COLS);
    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [TAB_SUM_W-1:0] TAB_MASK = TAB_SUM_W'(TAB_W - 1);

    typedef enum logic [1:0] {IDLE, EXEC, CLR_LINE, CLR_ALL} state_t;

    state_t                 state, state_n;
    logic [7:0]             pending_code, pending_code_n;
    logic [COL_W-1:0]       col_n, clr_col, clr_col_n;
    logic [ROW_W-1:0]       row_n, offset_n, clr_row, clr_row_n;
    logic                   wr_en_n;
    logic [COL_W+ROW_W-1:0] wr_addr_n;
    logic [7:0]             wr_data_n;

    logic [COL_W-1:0]       line_end [BUF_ROWS];
    logic                   le_set, le_zero, le_wipe;
    logic [ROW_W-1:0]       le_set_row, le_zero_row;
    logic [COL_W-1:0]       le_set_val;

    logic                   newline;
    logic [ROW_W-1:0]       phys_cur, phys_prev;
    logic [COL_W-1:0]       prev_end;
    logic [TAB_SUM_W-1:0]   tab_sum;

    // Physical rows wrap naturally in ROW_W bits.
    assign phys_cur  = cur_row + scroll_offset;
    assign phys_prev = cur_row - 1'b1 + scroll_offset;
    assign prev_end  = line_end[phys_prev];
    assign tab_sum   = ({1'b0, cur_col} | TAB_MASK) + 1'b1;

    assign in_ready  = (state == IDLE);
    assign clearing  = (state == CLR_LINE) || (state == CLR_ALL);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= CLR_ALL;
        else       state <= state_n;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n        = state;
        pending_code_n = pending_code;
        col_n          = cur_col;
        row_n          = cur_row;
        offset_n       = scroll_offset;
        clr_col_n      = clr_col;
        clr_row_n      = clr_row;
        wr_en_n        = 1'b0;
        wr_addr_n      = wr_addr;
        wr_data_n      = wr_data;
        le_set         = 1'b0;
        le_set_row     = phys_cur;
        le_set_val     = '0;
        le_zero        = 1'b0;
        le_zero_row    = '0;
        le_wipe        = 1'b0;
        newline        = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    pending_code_n = in_data;
                    state_n        = EXEC;
                end
            end

            EXEC: begin
                state_n = IDLE;
                if (pending_code >= 8'h20 && pending_code <= 8'h7E) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = {cur_col, phys_cur};
                    wr_data_n = pending_code;
                    if (cur_col < LAST_COL) begin
                        col_n = cur_col + 1'b1;
                    end else begin
                        le_set     = 1'b1;
                        le_set_val = COLS_END;
                        newline    = 1'b1;
                    end
                end else begin
                    case (pending_code)
                        8'h0A, 8'h0D: begin
                            le_set     = 1'b1;
                            le_set_val = cur_col;
                            newline    = 1'b1;
                        end
                        8'h08: begin
                            if (cur_col != '0) begin
                                col_n     = cur_col - 1'b1;
                                wr_en_n   = 1'b1;
                                wr_addr_n = {cur_col - 1'b1, phys_cur};
                                wr_data_n = 8'h00;
                            end else if (cur_row != '0) begin
                                // A full previous line means the cursor lands on, and erases, its last cell.
                                row_n = cur_row - 1'b1;
                                if (prev_end == COLS_END) begin
                                    col_n     = LAST_COL;
                                    wr_en_n   = 1'b1;
                                    wr_addr_n = {LAST_COL, phys_prev};
                                    wr_data_n = 8'h00;
                                end else begin
                                    col_n = prev_end;
                                end
                            end
                        end
                        8'h09: begin
                            col_n = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[COL_W-1:0];
                        end
                        8'h0C: begin
                            col_n     = '0;
                            row_n     = '0;
                            offset_n  = '0;
                            le_wipe   = 1'b1;
                            clr_col_n = '0;
                            clr_row_n = '0;
                            state_n   = CLR_ALL;
                        end
                        default: ;
                    endcase
                end

                if (newline) begin
                    col_n = '0;
                    if (cur_row < LAST_ROW) begin
                        row_n = cur_row + 1'b1;
                    end else begin
                        offset_n    = scroll_offset + 1'b1;
                        le_zero     = 1'b1;
                        le_zero_row = LAST_ROW + offset_n;
                        clr_col_n   = '0;
                        state_n     = CLR_LINE;
                    end
                end
            end

            CLR_LINE: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {clr_col, LAST_ROW + scroll_offset};
                wr_data_n = 8'h00;
                if (clr_col == LAST_COL) state_n = IDLE;
                else                     clr_col_n = clr_col + 1'b1;
            end

            CLR_ALL: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {clr_col, clr_row};
                wr_data_n = 8'h00;
                if (clr_col == LAST_COL) begin
                    clr_col_n = '0;
                    clr_row_n = clr_row + 1'b1;
                    if (clr_row == '1) state_n = IDLE;
                end else begin
                    clr_col_n = clr_col + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: line_end is reset on purpose: rows never terminated must read back as 0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pending_code  <= 8'h00;
            cur_col       <= '0;
            cur_row       <= '0;
            scroll_offset <= '0;
            clr_col       <= '0;
            clr_row       <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= 8'h00;
            for (int i = 0; i < BUF_ROWS; i++) line_end[i] <= '0;
        end else begin
            pending_code  <= pending_code_n;
            cur_col       <= col_n;
            cur_row       <= row_n;
            scroll_offset <= offset_n;
            clr_col       <= clr_col_n;
            clr_row       <= clr_row_n;
            wr_en         <= wr_en_n;
            wr_addr       <= wr_addr_n;
            wr_data       <= wr_data_n;
            if (le_wipe) begin
                for (int i = 0; i < BUF_ROWS; i++) line_end[i] <= '0;
            end else begin
                if (le_set)  line_end[le_set_row]  <= le_set_val;
                if (le_zero) line_end[le_zero_row] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: reset wipe, printing, wrap, backspace, tab,
// scrolling with line clears, form-feed clear and reset during a clear.
module tb_text_console_ctrl;
    localparam int COLS       = 70;
    localparam int ROWS       = 30;
    localparam int COL_W      = 7;
    localparam int ROW_W      = 5;
    localparam int TAB_W      = 4;
    localparam int BUF_ROWS   = 32;
    localparam int ALL_WRITES = COLS * BUF_ROWS;
    localparam int BOUND      = 5000;

    logic                   clk = 1'b0;
    logic                   clrn;
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   wr_en;
    logic [COL_W+ROW_W-1:0] wr_addr;
    logic [7:0]             wr_data;
    logic [ROW_W-1:0]       scroll_offset;
    logic [COL_W-1:0]       cur_col;
    logic [ROW_W-1:0]       cur_row;
    logic                   clearing;

    always #5 clk = ~clk;

    text_console_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .TAB_W(TAB_W)
    ) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_offset(scroll_offset), .cur_col(cur_col), .cur_row(cur_row),
        .clearing(clearing)
    );

    // Every write strobe is logged as {addr, data}.
    logic [19:0] wq[$];
    always @(negedge clk) if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] entry(input int col, input int row, input logic [7:0] data);
        logic [6:0] c;
        logic [4:0] r;
        c = 7'(col);
        r = 5'(row);
        return {c, r, data};
    endfunction

    function automatic logic [19:0] wq_at(input int k);
        if (k < wq.size()) return wq[k];
        return 20'hFFFFF;
    endfunction

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (!(in_ready === 1'b1 && clearing === 1'b0) && budget < BOUND) begin
            @(negedge clk);
            budget++;
        end
        check("idle_timeout", {30'b0, in_ready, clearing}, 32'h2);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = code;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < BOUND) begin
            @(negedge clk);
            budget++;
        end
        check("accept_timeout", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic count_clearing(output int n);
        n = 0;
        while (clearing === 1'b1 && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        #1;
    endtask

    task automatic check_clear_all(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < ALL_WRITES; k++)
            if (wq_at(k) !== entry(k % COLS, k / COLS, 8'h00)) bad++;
        check({tag, "_count"}, wq.size(), ALL_WRITES);
        check({tag, "_order"}, bad, 0);
        check({tag, "_first"}, wq_at(0), entry(0, 0, 8'h00));
        check({tag, "_last"}, wq_at(ALL_WRITES - 1), entry(69, 31, 8'h00));
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        logic busy_ok;

        clrn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clearing", clearing, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cursor", {cur_col, cur_row}, 0);
        check("rst_offset", scroll_offset, 0);

        // Reset-time wipe of the whole buffer
        wq.delete();
        clrn = 1'b1;
        count_clearing(n);
        check("wipe_cycles", n, ALL_WRITES);
        check_clear_all("wipe");
        check("wipe_ready", in_ready, 1);
        check("wipe_cursor", {cur_col, cur_row}, 0);

        // 'A' at (0,0): one write, one cycle after acceptance
        wq.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h41;
        check("a_ready_before", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("a_exec_not_ready", in_ready, 0);
        check("a_exec_no_write", wr_en, 0);
        @(negedge clk);
        check("a_wr_en", wr_en, 1);
        check("a_wr_addr", wr_addr, 12'h000);
        check("a_wr_data", wr_data, 8'h41);
        check("a_cur_col", cur_col, 1);
        check("a_ready_back", in_ready, 1);
        @(negedge clk);
        check("a_pulse_end", wr_en, 0);
        #1;
        check("a_one_write", wq.size(), 1);

        // Backspace to column 0, then 70 'x' wrapping to row 1
        wq.delete();
        send(8'h08);
        check("bs1_write", wq_at(0), entry(0, 0, 8'h00));
        check("bs1_col", cur_col, 0);
        wq.delete();
        repeat (COLS) send(8'h78);
        check("x70_count", wq.size(), 70);
        check("x70_first", wq_at(0), entry(0, 0, 8'h78));
        check("x70_last", wq_at(69), entry(69, 0, 8'h78));
        check("x70_cursor", {cur_col, cur_row}, {7'd0, 5'd1});
        wq.delete();
        send(8'h08);
        check("bs_wrap_count", wq.size(), 1);
        check("bs_wrap_write", wq_at(0), entry(69, 0, 8'h00));
        check("bs_wrap_cursor", {cur_col, cur_row}, {7'd69, 5'd0});

        // Form feed
        wq.delete();
        send(8'h0C);
        check_clear_all("ff1");
        check("ff1_cursor", {cur_col, cur_row}, 0);

        // Non-printable codes are consumed without effect
        wq.delete();
        send(8'h01);
        send(8'h7F);
        send(8'h1F);
        check("other_no_write", wq.size(), 0);
        check("other_cursor", {cur_col, cur_row}, 0);

        // "ab", CR, backspace returns to the short line end without writing
        send(8'h61);
        send(8'h62);
        send(8'h0D);
        check("ab_count", wq.size(), 2);
        check("ab_a", wq_at(0), entry(0, 0, 8'h61));
        check("ab_b", wq_at(1), entry(1, 0, 8'h62));
        check("cr_cursor", {cur_col, cur_row}, {7'd0, 5'd1});
        wq.delete();
        send(8'h08);
        check("bs_end_no_write", wq.size(), 0);
        check("bs_end_cursor", {cur_col, cur_row}, {7'd2, 5'd0});

        // Tabs
        send(8'h09);
        check("tab_2_to_4", cur_col, 4);
        repeat (16) send(8'h09);
        check("tab_to_68", cur_col, 68);
        send(8'h09);
        check("tab_68_to_69", cur_col, 69);
        send(8'h09);
        check("tab_69_stays", cur_col, 69);
        check("tab_no_write", wq.size(), 0);

        // 29 newlines down to the bottom row
        repeat (29) send(8'h0A);
        check("nl29_cursor", {cur_col, cur_row}, {7'd0, 5'd29});
        check("nl29_offset", scroll_offset, 0);

        // 30th newline scrolls; 'B' held valid during the line clear
        wq.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h0A;
        check("nl30_ready", in_ready, 1);
        @(negedge clk);
        in_data = 8'h42;
        check("nl30_exec_busy", in_ready, 0);
        @(negedge clk);
        n       = 0;
        busy_ok = 1'b1;
        while (clearing === 1'b1 && n < BOUND) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check("scroll1_clr_cycles", n, 70);
        check("scroll1_ready_low", busy_ok, 1);
        check("scroll1_offset", scroll_offset, 1);
        check("scroll1_cursor", {cur_col, cur_row}, {7'd0, 5'd29});
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        bad = 0;
        for (int c = 0; c < COLS; c++) if (wq_at(c) !== entry(c, 30, 8'h00)) bad++;
        check("scroll1_clr_order", bad, 0);
        check("scroll1_count", wq.size(), 71);
        check("scroll1_b_write", wq_at(70), entry(0, 30, 8'h42));
        check("scroll1_b_col", cur_col, 1);

        // Top printable code, then erase it
        wq.delete();
        send(8'h7E);
        send(8'h08);
        check("tilde_write", wq_at(0), entry(1, 30, 8'h7E));
        check("tilde_erase", wq_at(1), entry(1, 30, 8'h00));
        check("tilde_col", cur_col, 1);

        // Scrolls 2..33: offset and cleared physical row wrap mod 32
        for (int s = 2; s <= 33; s++) begin
            wq.delete();
            send(8'h0D);
            check($sformatf("scroll%0d_offset", s), scroll_offset, s % BUF_ROWS);
            check($sformatf("scroll%0d_count", s), wq.size(), 70);
            check($sformatf("scroll%0d_first", s), wq_at(0), entry(0, (29 + s) % BUF_ROWS, 8'h00));
            check($sformatf("scroll%0d_last", s), wq_at(69), entry(69, (29 + s) % BUF_ROWS, 8'h00));
        end
        check("scroll33_cursor", {cur_col, cur_row}, {7'd0, 5'd29});

        // Form feed from a scrolled screen
        wq.delete();
        send(8'h0C);
        check("ff2_offset", scroll_offset, 0);
        check("ff2_cursor", {cur_col, cur_row}, 0);
        check_clear_all("ff2");

        // Reset pulse in the middle of a full clear
        wq.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h0C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (101) @(negedge clk);
        #1;
        check("mid_clearing", clearing, 1);
        check("mid_wr_en", wr_en, 1);
        check("mid_progress", wq.size(), 100);
        check("mid_wr_addr", wr_addr, {7'd29, 5'd1});
        clrn = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_clearing", clearing, 1);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_cursor", {cur_col, cur_row, scroll_offset}, 0);
        repeat (2) @(negedge clk);
        check("mid_rst_hold", wq.size(), 100);
        wq.delete();
        clrn = 1'b1;
        count_clearing(n);
        check("restart_cycles", n, ALL_WRITES);
        check_clear_all("restart");

        // Line ends read 0 after reset: CR then backspace lands at (0,0) silently
        send(8'h0D);
        wq.delete();
        send(8'h08);
        check("post_rst_bs_cursor", {cur_col, cur_row}, 0);
        check("post_rst_bs_no_write", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
